mult_response_checker: RTL and testbench

- Response-side companion to the multiplier stimulus benches.
- Consumes operand pairs presented to a multiplier-under-test (A, B) and the DUT product P.
- Computes the golden product internally, aligns it to the DUT latency, compares, and accumulates pass/fail statistics.
- Synthesizable, so the same check can run in simulation and on FPGA alongside the multiplier.

---
 rtl/mult_response_checker.sv | 200 ++++++++++++++++++++
 tb/tb_mult_response_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_response_checker.sv
// Response checker for a multiplier under test: golden product, latency alignment, statistics.
// Optional response MISR on the signature output when MULT_CHK_SIGNATURE_EN is defined.
module mult_response_checker #(
  parameter int WIDTH       = 2,
  parameter int DUT_LATENCY = 0,
  parameter int NUM_VEC     = 20,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               vec_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] dut_p,
  output logic               vec_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b,
  output logic [2*WIDTH-1:0] first_err_p,
  output logic [2*WIDTH-1:0] first_err_exp,
  output logic [15:0]        signature
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] NUM_VEC_C  = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] LAST_VEC_C = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] issued;
  logic             accept;
  logic             run_start;
  logic [PW-1:0]    acc_exp;

  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [PW-1:0]    cmp_exp;
  logic             mismatch;

  assign vec_ready = (state == RUN) && (issued < NUM_VEC_C);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign accept    = vec_valid && vec_ready;
  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign acc_exp   = PW'(a) * PW'(b);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && (issued == LAST_VEC_C)) state_nxt = DRAIN;
      DRAIN:   if (vec_count == NUM_VEC_C) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      issued <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (run_start) begin
        issued <= '0;
        done   <= 1'b0;
        pass   <= 1'b0;
      end else begin
        if (accept) issued <= issued + CNT_ONE;
        // err_count is already final here: the last statistics update landed the edge before.
        if ((state == DRAIN) && (state_nxt == DONE)) begin
          done <= 1'b1;
          pass <= (err_count == '0);
        end
      end
    end
  end

  // The expected value travels alongside the DUT pipeline so it meets the matching product.
  generate
    if (DUT_LATENCY == 0) begin : g_lat0
      assign cmp_valid = accept;
      assign cmp_a     = a;
      assign cmp_b     = b;
      assign cmp_exp   = acc_exp;
    end else begin : g_pipe
      logic [DUT_LATENCY-1:0] dl_valid;
      logic [WIDTH-1:0]       dl_a   [DUT_LATENCY];
      logic [WIDTH-1:0]       dl_b   [DUT_LATENCY];
      logic [PW-1:0]          dl_exp [DUT_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dl_valid <= '0;
          for (int i = 0; i < DUT_LATENCY; i++) begin
            dl_a[i]   <= '0;
            dl_b[i]   <= '0;
            dl_exp[i] <= '0;
          end
        end else if (run_start) begin
          dl_valid <= '0;
        end else begin
          dl_valid[0] <= accept;
          dl_a[0]     <= a;
          dl_b[0]     <= b;
          dl_exp[0]   <= acc_exp;
          for (int i = 1; i < DUT_LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_a[i]     <= dl_a[i-1];
            dl_b[i]     <= dl_b[i-1];
            dl_exp[i]   <= dl_exp[i-1];
          end
        end
      end

      assign cmp_valid = dl_valid[DUT_LATENCY-1];
      assign cmp_a     = dl_a[DUT_LATENCY-1];
      assign cmp_b     = dl_b[DUT_LATENCY-1];
      assign cmp_exp   = dl_exp[DUT_LATENCY-1];
    end
  endgenerate

  assign mismatch = cmp_valid && (dut_p != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
      err_count <= '0;
    end else if (run_start) begin
      vec_count <= '0;
      err_count <= '0;
    end else if (cmp_valid) begin
      if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_ONE;
      if (mismatch && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
    end
  end

  // Only the first mismatch of a run is kept; later ones leave the capture alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_p     <= '0;
      first_err_exp   <= '0;
    end else if (run_start) begin
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_p     <= '0;
      first_err_exp   <= '0;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_a     <= cmp_a;
      first_err_b     <= cmp_b;
      first_err_p     <= dut_p;
      first_err_exp   <= cmp_exp;
    end
  end

`ifdef MULT_CHK_SIGNATURE_EN
  logic [15:0] misr;
  logic [15:0] misr_data;

  assign misr_data = 16'(dut_p);

  // CRC-CCITT style MISR (x^16+x^12+x^5+1) folding in every compared product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr <= '0;
    end else if (run_start) begin
      misr <= 16'hFFFF;
    end else if (cmp_valid && (state != DONE)) begin
      misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ misr_data;
    end
  end

  assign signature = misr;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_mult_response_checker.sv
// Bench for mult_response_checker: a latency-0 and a latency-2 checker watch the same stimulus.
// Signature checks follow MULT_CHK_SIGNATURE_EN, matching the RTL build.
module tb_mult_response_checker;

  localparam int WIDTH   = 2;
  localparam int PW      = 2 * WIDTH;
  localparam int NUM_VEC = 20;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             vec_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             corrupt;

  logic [PW-1:0] p_l0;
  logic [PW-1:0] p_stage1;
  logic [PW-1:0] p_stage2;

  // Multiplier-under-test models: combinational and two-stage pipelined, optionally broken for 3*3.
  always_comb p_l0 = (corrupt && (a == 2'd3) && (b == 2'd3)) ? 4'd4 : PW'(a) * PW'(b);

  always @(posedge clk) begin
    p_stage1 <= p_l0;
    p_stage2 <= p_stage1;
  end

  logic             vec_ready_l0, busy_l0, done_l0, pass_l0, fe_valid_l0;
  logic [CNT_W-1:0] vec_count_l0, err_count_l0;
  logic [WIDTH-1:0] fe_a_l0, fe_b_l0;
  logic [PW-1:0]    fe_p_l0, fe_exp_l0;
  logic [15:0]      signature_l0;

  logic             vec_ready_l2, busy_l2, done_l2, pass_l2, fe_valid_l2;
  logic [CNT_W-1:0] vec_count_l2, err_count_l2;
  logic [WIDTH-1:0] fe_a_l2, fe_b_l2;
  logic [PW-1:0]    fe_p_l2, fe_exp_l2;
  logic [15:0]      signature_l2;

  mult_response_checker #(.WIDTH(WIDTH), .DUT_LATENCY(0), .NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) u_chk_l0 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .a(a), .b(b), .dut_p(p_l0),
    .vec_ready(vec_ready_l0), .busy(busy_l0), .done(done_l0), .pass(pass_l0),
    .vec_count(vec_count_l0), .err_count(err_count_l0), .first_err_valid(fe_valid_l0),
    .first_err_a(fe_a_l0), .first_err_b(fe_b_l0), .first_err_p(fe_p_l0), .first_err_exp(fe_exp_l0),
    .signature(signature_l0)
  );

  mult_response_checker #(.WIDTH(WIDTH), .DUT_LATENCY(2), .NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) u_chk_l2 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .a(a), .b(b), .dut_p(p_stage2),
    .vec_ready(vec_ready_l2), .busy(busy_l2), .done(done_l2), .pass(pass_l2),
    .vec_count(vec_count_l2), .err_count(err_count_l2), .first_err_valid(fe_valid_l2),
    .first_err_a(fe_a_l2), .first_err_b(fe_b_l2), .first_err_p(fe_p_l2), .first_err_exp(fe_exp_l2),
    .signature(signature_l2)
  );

  typedef struct {
    int vec;
    int err;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  m_issued;
  int  m_vec;
  int  m_err;

  logic [1:0] tab_a [NUM_VEC] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2, 2'd3, 2'd0,
                                  2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
  logic [1:0] tab_b [NUM_VEC] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0,
                                  2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3};

`ifdef MULT_CHK_SIGNATURE_EN
  logic [15:0] m_sig;
  logic [15:0] sig_run1;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) begin
      n[0]  = ~n[0];
      n[5]  = ~n[5];
      n[12] = ~n[12];
    end
    return n ^ d;
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags_l0"}, {vec_ready_l0, busy_l0, done_l0, pass_l0, fe_valid_l0,
                                     fe_a_l0, fe_b_l0, fe_p_l0, fe_exp_l0}, 64'd0);
    checkOutput({tag, "_counts_l0"}, {vec_count_l0, err_count_l0, signature_l0}, 64'd0);
    checkOutput({tag, "_flags_l2"}, {vec_ready_l2, busy_l2, done_l2, pass_l2, fe_valid_l2,
                                     fe_a_l2, fe_b_l2, fe_p_l2, fe_exp_l2}, 64'd0);
    checkOutput({tag, "_counts_l2"}, {vec_count_l2, err_count_l2, signature_l2}, 64'd0);
  endtask

  task automatic startRun(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_issued = 0;
    m_vec    = 0;
    m_err    = 0;
`ifdef MULT_CHK_SIGNATURE_EN
    m_sig = 16'hFFFF;
`endif
    sb_q.delete();
    checkOutput({tag, "_busy"}, {busy_l0, busy_l2}, 64'b11);
    checkOutput({tag, "_done_pass_cleared"}, {done_l0, pass_l0, done_l2, pass_l2}, 64'd0);
    checkOutput({tag, "_counts_cleared"}, {vec_count_l0, err_count_l0, fe_valid_l0}, 64'd0);
  endtask

  // One vec_valid cycle; the scoreboard entry is the cumulative statistics expected after it.
  task automatic applyStimulus(input logic [1:0] av, input logic [1:0] bv);
    logic       rdy;
    logic [3:0] prod;
    sb_t        exp_e;
    @(negedge clk);
    vec_valid = 1'b1;
    a = av;
    b = bv;
    rdy = (m_issued < NUM_VEC);
    #1;
    checkOutput("vec_ready_l0", vec_ready_l0, rdy);
    checkOutput("vec_ready_l2", vec_ready_l2, rdy);
    if (rdy) begin
      prod = (corrupt && (av == 2'd3) && (bv == 2'd3)) ? 4'd4 : 4'(av) * 4'(bv);
      m_issued++;
      m_vec++;
      if (prod != 4'(av) * 4'(bv)) m_err++;
`ifdef MULT_CHK_SIGNATURE_EN
      m_sig = misr_step(m_sig, {12'd0, prod});
`endif
    end
    sb_q.push_back('{vec: m_vec, err: m_err});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 64'd1, 64'd0);
    end else begin
      exp_e = sb_q.pop_front();
      checkOutput("sb_vec_count_l0", vec_count_l0, exp_e.vec);
      checkOutput("sb_err_count_l0", err_count_l0, exp_e.err);
    end
  endtask

  task automatic stopVectors();
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  // Waits for both done flags; timed runs expect done_l0 on the first edge and done_l2 two later.
  task automatic finishRun(input string tag, input bit timed);
    int c0;
    int c2;
    c0 = -1;
    c2 = -1;
    for (int cyc = 0; (cyc < 30) && (c2 < 0); cyc++) begin
      @(posedge clk);
      #1;
      if ((c0 < 0) && done_l0) c0 = cyc;
      if ((c2 < 0) && done_l2) c2 = cyc;
    end
    checkOutput({tag, "_done_seen"}, {(c0 >= 0), (c2 >= 0)}, 64'b11);
    if (timed) begin
      checkOutput({tag, "_done_l0_cycle"}, c0, 0);
      checkOutput({tag, "_done_l2_delay"}, c2 - c0, 2);
    end
    checkOutput({tag, "_idle_flags"}, {busy_l0, busy_l2, vec_ready_l0, vec_ready_l2}, 64'd0);
    checkOutput({tag, "_vec_count_l0"}, vec_count_l0, 20);
    checkOutput({tag, "_vec_count_l2"}, vec_count_l2, 20);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_valid = 1'b0;
    a         = '0;
    b         = '0;
    corrupt   = 1'b0;
    m_issued  = 0;
    m_vec     = 0;
    m_err     = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_after_reset", {busy_l0, vec_ready_l0, done_l0}, 64'd0);

    // Run 1: correct DUT, back-to-back vectors.
    startRun("run1");
    for (int i = 0; i < NUM_VEC; i++) applyStimulus(tab_a[i], tab_b[i]);
    stopVectors();
    finishRun("run1", 1'b1);
    checkOutput("run1_pass", {pass_l0, pass_l2}, 64'b11);
    checkOutput("run1_err", {err_count_l0, err_count_l2}, 64'd0);
    checkOutput("run1_first_err_valid", {fe_valid_l0, fe_valid_l2}, 64'd0);
`ifdef MULT_CHK_SIGNATURE_EN
    sig_run1 = m_sig;
    checkOutput("run1_sig_l0", signature_l0, m_sig);
    checkOutput("run1_sig_l2", signature_l2, m_sig);
`else
    checkOutput("run1_sig_zero", {signature_l0, signature_l2}, 64'd0);
`endif

    // Run 2: DUT returns 4 for 3*3, restarted straight from DONE.
    corrupt = 1'b1;
    startRun("run2");
    for (int i = 0; i < NUM_VEC; i++) applyStimulus(tab_a[i], tab_b[i]);
    stopVectors();
    finishRun("run2", 1'b1);
    checkOutput("run2_err_l0", err_count_l0, 3);
    checkOutput("run2_err_l2", err_count_l2, 3);
    checkOutput("run2_pass", {pass_l0, pass_l2}, 64'd0);
    checkOutput("run2_first_err_l0", {fe_valid_l0, fe_a_l0, fe_b_l0, fe_p_l0, fe_exp_l0},
                {1'b1, 2'd3, 2'd3, 4'd4, 4'd9});
    checkOutput("run2_first_err_l2", {fe_valid_l2, fe_a_l2, fe_b_l2, fe_p_l2, fe_exp_l2},
                {1'b1, 2'd3, 2'd3, 4'd4, 4'd9});
`ifdef MULT_CHK_SIGNATURE_EN
    checkOutput("run2_sig_l0", signature_l0, m_sig);
    checkOutput("run2_sig_changed", (signature_l0 != sig_run1), 64'd1);
`else
    checkOutput("run2_sig_zero", {signature_l0, signature_l2}, 64'd0);
`endif
    corrupt = 1'b0;

    // Run 3: 25 pulses, the last five must be refused.
    startRun("run3");
    for (int i = 0; i < 25; i++) applyStimulus(tab_a[i % NUM_VEC], tab_b[i % NUM_VEC]);
    stopVectors();
    finishRun("run3", 1'b0);
    checkOutput("run3_pass", {pass_l0, pass_l2}, 64'b11);

    // Run 4: reset lands mid-run after ten vectors, then a clean restart.
    startRun("run4a");
    for (int i = 0; i < 10; i++) applyStimulus(tab_a[i], tab_b[i]);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    @(negedge clk);
    vec_valid = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    startRun("run4b");
    for (int i = 0; i < NUM_VEC; i++) applyStimulus(tab_a[i], tab_b[i]);
    stopVectors();
    finishRun("run4b", 1'b1);
    checkOutput("run4b_err", {err_count_l0, err_count_l2}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
